i2c_temp_responder: RTL

- I2C target that emulates the ADT7420 temperature sensor on the bus, for closed-loop simulation and board self-test of the I2C master.
- The master's SCL runs at 100 kHz, produced from the 200 kHz toggle clock.
- The block oversamples SCL/SDA at 100 MHz, detects START/STOP, ACKs its 7-bit address, and serves a 16-bit temperature word on reads.
- Written bytes are ACKed and exposed to the system side.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_line_filter.sv | 71 +++++++
 rtl/i2c_temp_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the ADT7420-emulating I2C responder.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RD_BYTE  = 3'd3,
        RD_ACK   = 3'd4,
        WR_BYTE  = 3'd5,
        WR_ACK   = 3'd6
    } i2c_state_e;

    localparam logic [6:0] ADT7420_ADDR = 7'h4B;
    localparam logic [7:0] TEMP_MSB     = 8'h00;
    localparam logic [7:0] TEMP_LSB     = 8'h01;

    // Pick the temperature byte addressed by the register pointer.
    function automatic logic [7:0] temp_byte(input logic [15:0] word, input logic [7:0] reg_ptr);
        logic [7:0] result;
        if (reg_ptr == TEMP_LSB) begin
            result = word[7:0];
        end else begin
            result = word[15:8];
        end
        return result;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Pad-line conditioning: 2-FF synchronizer, optional glitch filter
// (enabled by I2C_GLITCH_FILTER_EN), one-cycle rise/fall strobes.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_raw,
    output logic line_filt,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic filt_s;
    logic prev_r;

    // Two-stage synchronizer for the asynchronous pad input; idles high like the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= line_raw;
            sync2_r <= sync1_r;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic             filt_r;
    logic [CNT_W-1:0] cnt_r;

    // Accept a new level only after FILT_LEN consecutive samples that disagree with the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r <= 1'b1;
            cnt_r  <= CNT_W'(0);
        end else if (sync2_r == filt_r) begin
            cnt_r  <= CNT_W'(0);
        end else if (cnt_r == CNT_W'(FILT_LEN - 1)) begin
            filt_r <= sync2_r;
            cnt_r  <= CNT_W'(0);
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

    assign filt_s = filt_r;
`else
    assign filt_s = sync2_r;
`endif

    // Previous filtered level, used to form the edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= filt_s;
        end
    end

    assign line_filt = filt_s;
    assign rise      = filt_s & ~prev_r;
    assign fall      = ~filt_s & prev_r;

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target emulating the ADT7420: ACKs its address, serves the temperature
// word on reads, exposes written bytes. Glitch filter via I2C_GLITCH_FILTER_EN.
module i2c_temp_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = ADT7420_ADDR,
    parameter int         FILT_LEN = 4
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_data,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    output logic        busy
);

    logic scl_f_s, scl_rise_s, scl_fall_s;
    logic sda_f_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s, addr_hit_s;

    i2c_state_e  state_r, state_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s;
    logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic        full_r, full_nxt_s;
    logic        rw_r, rw_nxt_s;
    logic [7:0]  byte_sel_r, byte_sel_nxt_s;
    logic [15:0] shadow_r, shadow_nxt_s;
    logic        sda_oe_r, sda_oe_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        wr_valid_r, wr_valid_nxt_s;
    logic [7:0]  wr_data_r, wr_data_nxt_s;
    logic [7:0]  cur_byte_s;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filter (
        .clk       (clk_100MHz),
        .rst_n     (rst_n),
        .line_raw  (scl_in),
        .line_filt (scl_f_s),
        .rise      (scl_rise_s),
        .fall      (scl_fall_s)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filter (
        .clk       (clk_100MHz),
        .rst_n     (rst_n),
        .line_raw  (sda_in),
        .line_filt (sda_f_s),
        .rise      (sda_rise_s),
        .fall      (sda_fall_s)
    );

    assign start_s    = sda_fall_s & scl_f_s;
    assign stop_s     = sda_rise_s & scl_f_s;
    assign addr_hit_s = (shift_r[7:1] == DEV_ADDR);

    // State register.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; bus conditions override bit-level sequencing.
    always_comb begin
        state_nxt_s = state_r;
        if (start_s) begin
            state_nxt_s = ADDR;
        end else if (stop_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: state_nxt_s = IDLE;
                ADDR: begin
                    if (scl_fall_s && full_r) begin
                        state_nxt_s = addr_hit_s ? ADDR_ACK : IDLE;
                    end else begin
                        state_nxt_s = ADDR;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s) begin
                        state_nxt_s = rw_r ? RD_BYTE : WR_BYTE;
                    end else begin
                        state_nxt_s = ADDR_ACK;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall_s && (bit_cnt_r == 3'd7)) begin
                        state_nxt_s = RD_ACK;
                    end else begin
                        state_nxt_s = RD_BYTE;
                    end
                end
                RD_ACK: begin
                    // NACK parks in IDLE with busy still set until STOP or repeated START.
                    if (scl_rise_s && sda_f_s) begin
                        state_nxt_s = IDLE;
                    end else if (scl_fall_s) begin
                        state_nxt_s = RD_BYTE;
                    end else begin
                        state_nxt_s = RD_ACK;
                    end
                end
                WR_BYTE: begin
                    if (scl_fall_s && full_r) begin
                        state_nxt_s = WR_ACK;
                    end else begin
                        state_nxt_s = WR_BYTE;
                    end
                end
                WR_ACK: begin
                    if (scl_fall_s) begin
                        state_nxt_s = WR_BYTE;
                    end else begin
                        state_nxt_s = WR_ACK;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Datapath and output next values; shift_r doubles as receive and transmit shifter.
    always_comb begin
        shift_nxt_s    = shift_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        full_nxt_s     = full_r;
        rw_nxt_s       = rw_r;
        byte_sel_nxt_s = byte_sel_r;
        shadow_nxt_s   = shadow_r;
        sda_oe_nxt_s   = sda_oe_r;
        busy_nxt_s     = busy_r;
        wr_valid_nxt_s = 1'b0;
        wr_data_nxt_s  = wr_data_r;
        cur_byte_s     = temp_byte(shadow_r, byte_sel_r);
        if (start_s) begin
            bit_cnt_nxt_s = 3'd0;
            full_nxt_s    = 1'b0;
            sda_oe_nxt_s  = 1'b0;
            busy_nxt_s    = 1'b1;
        end else if (stop_s) begin
            sda_oe_nxt_s  = 1'b0;
            busy_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                ADDR, WR_BYTE: begin
                    if (scl_rise_s) begin
                        shift_nxt_s   = {shift_r[6:0], sda_f_s};
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        full_nxt_s    = (bit_cnt_r == 3'd7);
                    end else if (scl_fall_s && full_r) begin
                        full_nxt_s = 1'b0;
                        if (state_r == WR_BYTE) begin
                            wr_data_nxt_s  = shift_r;
                            wr_valid_nxt_s = 1'b1;
                            sda_oe_nxt_s   = 1'b1;
                        end else if (addr_hit_s) begin
                            sda_oe_nxt_s = 1'b1;
                            rw_nxt_s     = shift_r[0];
                            if (shift_r[0]) begin
                                shadow_nxt_s   = temp_data;
                                byte_sel_nxt_s = TEMP_MSB;
                            end else begin
                                shadow_nxt_s   = shadow_r;
                            end
                        end else begin
                            busy_nxt_s = 1'b0;
                        end
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s && rw_r) begin
                        shift_nxt_s   = cur_byte_s;
                        sda_oe_nxt_s  = ~cur_byte_s[7];
                        bit_cnt_nxt_s = 3'd0;
                    end else if (scl_fall_s) begin
                        sda_oe_nxt_s  = 1'b0;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        sda_oe_nxt_s  = sda_oe_r;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall_s && (bit_cnt_r == 3'd7)) begin
                        sda_oe_nxt_s  = 1'b0;
                        bit_cnt_nxt_s = 3'd0;
                    end else if (scl_fall_s) begin
                        shift_nxt_s   = {shift_r[6:0], 1'b0};
                        sda_oe_nxt_s  = ~shift_r[6];
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    end else begin
                        sda_oe_nxt_s  = sda_oe_r;
                    end
                end
                RD_ACK: begin
                    if (scl_fall_s) begin
                        byte_sel_nxt_s = (byte_sel_r == TEMP_MSB) ? TEMP_LSB : TEMP_MSB;
                        cur_byte_s     = temp_byte(shadow_r, byte_sel_nxt_s);
                        shift_nxt_s    = cur_byte_s;
                        sda_oe_nxt_s   = ~cur_byte_s[7];
                        bit_cnt_nxt_s  = 3'd0;
                    end else begin
                        sda_oe_nxt_s   = sda_oe_r;
                    end
                end
                WR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_nxt_s  = 1'b0;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        sda_oe_nxt_s  = sda_oe_r;
                    end
                end
                default: begin
                    sda_oe_nxt_s = sda_oe_r;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            full_r     <= 1'b0;
            rw_r       <= 1'b0;
            byte_sel_r <= TEMP_MSB;
            shadow_r   <= 16'h0000;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_data_r  <= 8'h00;
        end else begin
            shift_r    <= shift_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            full_r     <= full_nxt_s;
            rw_r       <= rw_nxt_s;
            byte_sel_r <= byte_sel_nxt_s;
            shadow_r   <= shadow_nxt_s;
            sda_oe_r   <= sda_oe_nxt_s;
            busy_r     <= busy_nxt_s;
            wr_valid_r <= wr_valid_nxt_s;
            wr_data_r  <= wr_data_nxt_s;
        end
    end

    assign sda_oe   = sda_oe_r;
    assign busy     = busy_r;
    assign wr_valid = wr_valid_r;
    assign wr_data  = wr_data_r;

endmodule
